uart_cmd_decoder: RTL and testbench

Command front-end of each FPGA_modulo: consumes bytes from the module's `uart_rx`, corrects and decodes Hamming(7,4) commands sent by the master's `uart_tx`, and drives the SPWM enable. It sends an ACK/NACK byte back through the module's `uart_tx`. A link watchdog forces the SPWM off if no valid command arrives within a programmable window.

---
 rtl/uart_cmd_decoder_pkg.sv | 36 +++
 rtl/uart_cmd_decoder_if.sv | 21 ++
 rtl/uart_cmd_decoder_hamming.sv | 21 ++
 rtl/uart_cmd_decoder.sv | 170 +++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_decoder_pkg.sv
// Shared types and constants for the UART command decoder.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_REPLY_REQ,
        ST_REPLY_WAIT
    } state_t;

    typedef enum logic [1:0] {
        CLS_ON,
        CLS_OFF,
        CLS_TOGGLE,
        CLS_UNKNOWN
    } cmd_class_t;

    localparam logic [3:0] CMD_ON        = 4'h6;
    localparam logic [3:0] CMD_OFF       = 4'hD;
    localparam logic [7:0] LIT_TOGGLE    = 8'h4D;
    localparam logic [7:0] DEF_ACK_BYTE  = 8'h3C;
    localparam logic [7:0] DEF_NACK_BYTE = 8'hC3;

    // Bit7 selects Hamming frame (use corrected nibble) or literal byte.
    function automatic cmd_class_t classify(input logic [7:0] raw, input logic [3:0] nib);
        if (raw[7]) begin
            if (nib == CMD_ON)  return CLS_ON;
            if (nib == CMD_OFF) return CLS_OFF;
            return CLS_UNKNOWN;
        end
        if (raw == LIT_TOGGLE) return CLS_TOGGLE;
        return CLS_UNKNOWN;
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Byte-level link between the decoder and its uart_rx / uart_tx pair.
interface uart_cmd_decoder_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_parity_error;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;

    // UART side: delivers received bytes and reports transmitter state.
    modport master (
        output rx_data, rx_done, rx_parity_error, tx_busy,
        input  tx_start, tx_data
    );

    // Decoder side.
    modport slave (
        input  rx_data, rx_done, rx_parity_error, tx_busy,
        output tx_start, tx_data
    );
endinterface

// File: rtl/uart_cmd_decoder_hamming.sv
// Hamming(7,4) single-error-correcting decoder, mirror of hamming_7_4_encoder.
// Code layout {d4,d3,d2,p3,d1,p2,p1}; a nonzero syndrome k flips bit k-1.
module hamming_7_4_decoder (
    input  logic [6:0] code_in,
    output logic [3:0] data_out,
    output logic       corrected
);
    logic [2:0] syn;
    logic [6:0] fixed;

    // Syndrome, correction and data extraction.
    always_comb begin
        syn[0] = code_in[0] ^ code_in[2] ^ code_in[4] ^ code_in[6];
        syn[1] = code_in[1] ^ code_in[2] ^ code_in[5] ^ code_in[6];
        syn[2] = code_in[3] ^ code_in[4] ^ code_in[5] ^ code_in[6];
        fixed  = code_in;
        if (syn != 3'd0) fixed = code_in ^ (7'b1 << (syn - 3'd1));
        data_out  = {fixed[6], fixed[5], fixed[4], fixed[2]};
        corrected = |syn;
    end
endmodule

// File: rtl/uart_cmd_decoder.sv
// Command front-end: holds one received byte, decodes it, drives the SPWM
// enable, replies ACK/NACK through uart_tx and runs the link watchdog.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 48000000,
    parameter logic [7:0]  ACK_BYTE       = DEF_ACK_BYTE,
    parameter logic [7:0]  NACK_BYTE      = DEF_NACK_BYTE
) (
    input  logic                clk,
    input  logic                reset,
    uart_cmd_decoder_if.slave   bus,
    output logic                pwm_enable,
    output logic                cmd_valid,
    output logic [3:0]          cmd_code,
    output logic [7:0]          err_count,
    output logic                link_timeout
);
    localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES);

    state_t     state_q, state_d;
    cmd_class_t cls_q, cls_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_vld_q, hold_vld_d;
    logic [7:0] byte_q, byte_d;
    logic [3:0] nib_q, nib_d;
    logic       pwm_q, pwm_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [3:0] cmd_code_q, cmd_code_d;
    logic       tx_start_q, tx_start_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [7:0] err_q, err_d;
    logic [31:0] wdog_q, wdog_d;
    logic       link_to_q, link_to_d;

    logic [3:0] ham_data;
    logic       leave_idle;
    logic       ack_exec;

    hamming_7_4_decoder u_ham (
        .code_in   (byte_q[6:0]),
        .data_out  (ham_data),
        .corrected ()
    );

    assign leave_idle = (state_q == ST_IDLE) && hold_vld_q;
    assign ack_exec   = (state_q == ST_EXEC) && (cls_q != CLS_UNKNOWN);

    // Hold register and error counter; a strobe that finds the register
    // full (even while it is being drained) is counted as an overrun.
    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        err_d      = err_q;
        if (leave_idle) hold_vld_d = 1'b0;
        if (bus.rx_done) begin
            if (bus.rx_parity_error || hold_vld_q) begin
                if (err_q != 8'hFF) err_d = err_q + 8'd1;
            end else begin
                hold_d     = bus.rx_data;
                hold_vld_d = 1'b1;
            end
        end
    end

    // Watchdog: only ACKed commands feed it; an ACK on the saturating cycle wins.
    always_comb begin
        if (ack_exec)              wdog_d = 32'd0;
        else if (wdog_q >= WD_LIMIT) wdog_d = WD_LIMIT;
        else                       wdog_d = wdog_q + 32'd1;
        link_to_d = !ack_exec && (wdog_d == WD_LIMIT);
    end

    // Command FSM next state and registered outputs.
    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        nib_d       = nib_q;
        cls_d       = cls_q;
        pwm_d       = pwm_q;
        cmd_valid_d = 1'b0;
        cmd_code_d  = cmd_code_q;
        tx_start_d  = tx_start_q;
        tx_data_d   = tx_data_q;
        case (state_q)
            ST_IDLE: begin
                if (hold_vld_q) begin
                    byte_d  = hold_q;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                nib_d   = byte_q[7] ? ham_data : byte_q[3:0];
                cls_d   = classify(byte_q, ham_data);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (cls_q)
                    CLS_ON:     pwm_d = 1'b1;
                    CLS_OFF:    pwm_d = 1'b0;
                    CLS_TOGGLE: pwm_d = ~pwm_q;
                    default:    pwm_d = pwm_q;
                endcase
                if (cls_q != CLS_UNKNOWN) begin
                    cmd_valid_d = 1'b1;
                    cmd_code_d  = nib_q;
                    tx_data_d   = ACK_BYTE;
                end else begin
                    tx_data_d   = NACK_BYTE;
                end
                tx_start_d = 1'b1;
                state_d    = ST_REPLY_REQ;
            end
            ST_REPLY_REQ: begin
                if (bus.tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = ST_REPLY_WAIT;
                end
            end
            ST_REPLY_WAIT: begin
                if (!bus.tx_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (link_to_d) pwm_d = 1'b0;
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cls_q       <= CLS_UNKNOWN;
            hold_q      <= 8'd0;
            hold_vld_q  <= 1'b0;
            byte_q      <= 8'd0;
            nib_q       <= 4'd0;
            pwm_q       <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= 4'd0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= ACK_BYTE;
            err_q       <= 8'd0;
            wdog_q      <= 32'd0;
            link_to_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cls_q       <= cls_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            byte_q      <= byte_d;
            nib_q       <= nib_d;
            pwm_q       <= pwm_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            err_q       <= err_d;
            wdog_q      <= wdog_d;
            link_to_q   <= link_to_d;
        end
    end

    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign pwm_enable    = pwm_q;
    assign cmd_valid     = cmd_valid_q;
    assign cmd_code      = cmd_code_q;
    assign err_count     = err_q;
    assign link_timeout  = link_to_q;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: decode, replies, errors, watchdog, reset.
module tb_uart_cmd_decoder;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pwm_enable, cmd_valid, link_timeout;
    logic [3:0] cmd_code;
    logic [7:0] err_count;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         ack_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_cmd_decoder_if bus ();

    uart_cmd_decoder #(
        .TIMEOUT_CYCLES (100),
        .ACK_BYTE       (8'h3C),
        .NACK_BYTE      (8'hC3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .pwm_enable   (pwm_enable),
        .cmd_valid    (cmd_valid),
        .cmd_code     (cmd_code),
        .err_count    (err_count),
        .link_timeout (link_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the byte is sampled on the next posedge (edge N).
    task automatic send(input logic [7:0] b, input logic perr);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        bus.rx_parity_error = perr;
        @(negedge clk);
        bus.rx_done = 1'b0;
        bus.rx_parity_error = 1'b0;
    endtask

    // From just after edge N: checks at N+2 and N+3.
    task automatic exec_chk(input string tag, input logic pre, input logic pwm,
                            input logic valid, input logic [3:0] code, input logic [7:0] tx);
        @(posedge clk); @(posedge clk); #1;
        check({tag, ":pwm_pre"}, pwm_enable, pre);
        check({tag, ":start_pre"}, bus.tx_start, 0);
        @(posedge clk); #1;
        ack_cyc = cyc;
        check({tag, ":pwm"}, pwm_enable, pwm);
        check({tag, ":valid"}, cmd_valid, valid);
        check({tag, ":code"}, cmd_code, code);
        check({tag, ":start"}, bus.tx_start, 1);
        check({tag, ":txdata"}, bus.tx_data, tx);
    endtask

    // Plays uart_tx: delayed busy, then release; returns at a negedge in IDLE.
    task automatic handshake(input string tag, input logic [7:0] tx);
        @(posedge clk); #1;
        check({tag, ":valid_off"}, cmd_valid, 0);
        check({tag, ":start_hold"}, bus.tx_start, 1);
        @(negedge clk); bus.tx_busy = 1'b1;
        @(posedge clk); #1;
        check({tag, ":start_drop"}, bus.tx_start, 0);
        check({tag, ":txdata_hold"}, bus.tx_data, tx);
        @(negedge clk); @(negedge clk); bus.tx_busy = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_cmd(input string tag, input logic [7:0] b, input logic pre,
                           input logic pwm, input logic valid, input logic [3:0] code,
                           input logic [7:0] tx);
        send(b, 1'b0);
        exec_chk(tag, pre, pwm, valid, code, tx);
        handshake(tag, tx);
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, ":tx_start"}, bus.tx_start, 0);
        check({tag, ":tx_data"}, bus.tx_data, 8'h3C);
        check({tag, ":pwm"}, pwm_enable, 0);
        check({tag, ":valid"}, cmd_valid, 0);
        check({tag, ":code"}, cmd_code, 0);
        check({tag, ":err"}, err_count, 0);
        check({tag, ":link"}, link_timeout, 0);
    endtask

    initial begin
        bus.rx_data = 8'h00;
        bus.rx_done = 1'b0;
        bus.rx_parity_error = 1'b0;
        bus.tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b1;
        @(negedge clk);

        // Hamming commands, including a single-bit correction.
        run_cmd("on_b3",    8'hB3, 1'b0, 1'b1, 1'b1, 4'h6, 8'h3C);
        run_cmd("corr_a3",  8'hA3, 1'b1, 1'b1, 1'b1, 4'h6, 8'h3C);
        run_cmd("off_e6",   8'hE6, 1'b1, 1'b0, 1'b1, 4'hD, 8'h3C);
        // Literal toggle twice, then ON so the NACK can show pwm unchanged.
        run_cmd("tog1",     8'h4D, 1'b0, 1'b1, 1'b1, 4'hD, 8'h3C);
        run_cmd("tog2",     8'h4D, 1'b1, 1'b0, 1'b1, 4'hD, 8'h3C);
        run_cmd("on2",      8'hB3, 1'b0, 1'b1, 1'b1, 4'h6, 8'h3C);
        run_cmd("nack_11",  8'h11, 1'b1, 1'b1, 1'b0, 4'h6, 8'hC3);

        // Parity-flagged OFF command must be dropped silently.
        send(8'hE6, 1'b1);
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        check("perr:start", bus.tx_start, 0);
        check("perr:pwm", pwm_enable, 1);
        check("perr:err", err_count, 1);
        @(negedge clk);

        // Overrun: three strobes during REPLY_WAIT, only the first is kept.
        send(8'h4D, 1'b0);
        exec_chk("ovr_tog", 1'b1, 1'b0, 1'b1, 4'hD, 8'h3C);
        @(negedge clk); bus.tx_busy = 1'b1;
        @(negedge clk);
        bus.rx_data = 8'hB3; bus.rx_done = 1'b1;
        @(negedge clk); bus.rx_data = 8'hE6;
        @(negedge clk); bus.rx_data = 8'hE6;
        @(negedge clk); bus.rx_done = 1'b0; bus.tx_busy = 1'b0;
        check("ovr:err", err_count, 3);
        @(negedge clk);
        exec_chk("ovr_held", 1'b0, 1'b1, 1'b1, 4'h6, 8'h3C);
        handshake("ovr_held", 8'h3C);

        // Watchdog expiry exactly 100 cycles after the last ACK.
        while (cyc < ack_cyc + 99) @(negedge clk);
        check("wd99:link", link_timeout, 0);
        check("wd99:pwm", pwm_enable, 1);
        @(negedge clk);
        check("wd100:link", link_timeout, 1);
        check("wd100:pwm", pwm_enable, 0);
        send(8'hB3, 1'b0);
        exec_chk("wd_rec", 1'b0, 1'b1, 1'b1, 4'h6, 8'h3C);
        check("wd_rec:link", link_timeout, 0);
        handshake("wd_rec", 8'h3C);

        // ACK lands on the very cycle the watchdog would saturate.
        while (cyc < ack_cyc + 96) @(negedge clk);
        send(8'hB3, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        check("wd_tie:link_pre", link_timeout, 0);
        @(posedge clk); #1;
        check("wd_tie:link", link_timeout, 0);
        check("wd_tie:pwm", pwm_enable, 1);
        check("wd_tie:valid", cmd_valid, 1);
        handshake("wd_tie", 8'h3C);

        // Reset in the middle of a NACK reply.
        send(8'h11, 1'b0);
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        check("mid:start", bus.tx_start, 1);
        check("mid:txdata", bus.tx_data, 8'hC3);
        #2 reset = 1'b0;
        #1 chk_reset_vals("mid_rst");
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        run_cmd("post_rst", 8'hB3, 1'b0, 1'b1, 1'b1, 4'h6, 8'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
